// File: rtl/tdm_demux.sv
// TDM frame demultiplexer: steers serial samples into per-channel registers,
// tracking frame alignment through frame_sync and resynchronising on errors.
module tdm_demux #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 8,
  localparam int SW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      frame_sync,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  output logic                      frame_done,
  output logic                      locked,
  output logic [SW-1:0]             slot,
  output logic                      sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  state_t                      state;
  state_t                      state_nxt;
  logic [SW-1:0]               slot_nxt;
  logic [CHANNELS*WIDTH-1:0]   data_nxt;
  logic [CHANNELS-1:0]         valid_nxt;
  logic                        done_nxt;
  logic                        err_nxt;
  logic                        wr;
  logic [SW-1:0]               wr_idx;
  logic                        first;

  assign first  = (slot == '0);
  assign locked = (state == LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= '0;
      out_data   <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      slot       <= slot_nxt;
      out_data   <= data_nxt;
      out_valid  <= valid_nxt;
      frame_done <= done_nxt;
      sync_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    wr        = 1'b0;
    wr_idx    = '0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            wr        = 1'b1;
            slot_nxt  = ONE;
            state_nxt = LOCK;
          end
        end
        LOCK: begin
          unique case (1'b1)
            // an early sync truncates the frame and restarts at slot 0
            frame_sync: begin
              wr       = 1'b1;
              slot_nxt = ONE;
              err_nxt  = !first;
            end
            !frame_sync && !first: begin
              wr     = 1'b1;
              wr_idx = slot;
              if (slot == LAST) begin
                done_nxt = 1'b1;
                slot_nxt = '0;
              end else begin
                slot_nxt = slot + ONE;
              end
            end
            !frame_sync && first: begin
              err_nxt   = 1'b1;
              slot_nxt  = '0;
              state_nxt = HUNT;
            end
            default: ;
          endcase
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    data_nxt  = out_data;
    valid_nxt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (wr && wr_idx == SW'(k)) begin
        data_nxt[k*WIDTH +: WIDTH] = in_data;
        valid_nxt[k]               = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: directed test-plan sequences followed by
// randomized traffic, checked against a slot-level frame model.
module tb_tdm_demux;

  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [W-1:0]    in_data;
  logic            frame_sync;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0]   out_valid;
  logic            frame_done;
  logic            locked;
  logic [1:0]      slot;
  logic            sync_err;

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .frame_sync(frame_sync),
    .out_data(out_data),
    .out_valid(out_valid),
    .frame_done(frame_done),
    .locked(locked),
    .slot(slot),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [CH-1:0] ov;
    logic        fd;
    logic        se;
  } exp_t;

  exp_t   q[$];
  int     edge_cnt = 0;
  int     passed = 0;
  int     total = 0;
  bit     mon_en = 0;

  bit         m_locked;
  int         m_slot;
  logic [W-1:0] m_data[CH];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [CH*W-1:0] packed_model();
    logic [CH*W-1:0] p;
    for (int k = 0; k < CH; k++) p[k*W +: W] = m_data[k];
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h",
                  name, edge_cnt, got, exp);
  endtask

  // Frame rules at slot level; expected strobes go to the scoreboard
  task automatic model_step(input bit r, input bit v, input bit fs,
                            input logic [W-1:0] d);
    exp_t e;
    e.cyc = edge_cnt + 1;
    e.ov  = '0;
    e.fd  = 0;
    e.se  = 0;
    if (r) begin
      m_locked = 0;
      m_slot   = 0;
      for (int k = 0; k < CH; k++) m_data[k] = '0;
      return;
    end
    if (!v) return;
    if (!m_locked) begin
      if (fs) begin
        m_data[0] = d; e.ov[0] = 1; m_slot = 1; m_locked = 1;
      end
    end else if (fs) begin
      e.se = (m_slot != 0);
      m_data[0] = d; e.ov[0] = 1; m_slot = 1;
    end else if (m_slot == 0) begin
      e.se = 1; m_locked = 0;
    end else begin
      m_data[m_slot] = d;
      e.ov[m_slot] = 1;
      e.fd = (m_slot == CH - 1);
      m_slot = (m_slot + 1) % CH;
    end
    if (e.ov != 0 || e.fd || e.se) q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit v, input bit fs,
                       input logic [W-1:0] d);
    @(negedge clk);
    rst = r; in_valid = v; frame_sync = fs; in_data = d;
    model_step(r, v, fs, d);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, $urandom_range(0, 1), 8'hEE);
  endtask

  task automatic frame(input logic [W-1:0] base, input int g);
    for (int k = 0; k < CH; k++) begin
      drive(0, 1, k == 0, base + W'(k));
      gap(g);
    end
  endtask

  // Monitor: per-cycle state compare plus scoreboard pop on any strobe
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        check("locked", 64'(locked), 64'(m_locked));
        check("slot", 64'(slot), 64'(m_slot));
        check("out_data", 64'(out_data), 64'(packed_model()));
        while (q.size() > 0 && q[0].cyc < edge_cnt) begin
          e = q.pop_front();
          check("missed_strobe_cycle", 64'(edge_cnt), 64'(e.cyc));
        end
        if (q.size() > 0 && q[0].cyc == edge_cnt) begin
          e = q.pop_front();
          check("out_valid", 64'(out_valid), 64'(e.ov));
          check("frame_done", 64'(frame_done), 64'(e.fd));
          check("sync_err", 64'(sync_err), 64'(e.se));
        end else begin
          check("idle_strobes", 64'({out_valid, frame_done, sync_err}), 64'(0));
        end
      end
    end
  end

  initial begin
    rst = 1; in_valid = 0; frame_sync = 0; in_data = '0;
    drive(1, 1, 1, 8'h11);
    mon_en = 1;
    drive(1, 0, 0, 8'h00);

    // reset while locked mid-frame, then an unsynced beat is dropped
    drive(0, 1, 1, 8'h10);
    drive(0, 1, 0, 8'h11);
    drive(1, 1, 0, 8'h12);
    drive(0, 1, 0, 8'h55);
    gap(1);

    frame(8'hA0, 0);
    gap(2);
    frame(8'hA0, 3);

    // early sync
    drive(0, 1, 1, 8'hB0);
    drive(0, 1, 0, 8'hB1);
    drive(0, 1, 1, 8'hC0);
    gap(1);

    // missing sync, then discard and relock
    drive(0, 1, 0, 8'hC1);
    drive(0, 1, 0, 8'hC2);
    drive(0, 1, 0, 8'hC3);
    drive(0, 1, 0, 8'hDD);
    gap(1);
    drive(0, 1, 0, 8'h77);
    drive(0, 1, 1, 8'hE0);
    drive(0, 1, 0, 8'hE1);
    drive(0, 1, 0, 8'hE2);
    drive(0, 1, 0, 8'hE3);

    // back-to-back frames
    for (int f = 0; f < 3; f++) frame(8'h40 + W'(f * 16), 0);
    gap(2);

    for (int i = 0; i < 3000; i++) begin
      bit r, v, fs;
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 9) < 7);
      if (!m_locked) fs = ($urandom_range(0, 9) < 4);
      else if (m_slot == 0) fs = ($urandom_range(0, 19) < 17);
      else fs = ($urandom_range(0, 19) < 2);
      drive(r, v, fs, W'($urandom));
    end

    gap(4);
    check("queue_empty", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
